// File: rtl/icache_direct.sv
// ============================================================================
// Module      : icache_direct
// Description : Direct-mapped read-only instruction cache, 4-word blocks,
//               zero-latency hits and single-block refill on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_direct #(
    parameter int BLOCKS = 8,
    parameter int AW     = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            proc_read_i,
    input  logic [AW-1:0]   proc_addr_i,
    output logic [31:0]     proc_rdata_o,
    output logic            proc_stall_o,
    output logic            mem_read_o,
    output logic [AW-3:0]   mem_addr_o,
    input  logic [127:0]    mem_rdata_i,
    input  logic            mem_ready_i
);

    localparam int IW = $clog2(BLOCKS);
    localparam int TW = AW - 2 - IW;

    typedef enum logic [0:0] {
        S_COMPARE  = 1'b0,
        S_ALLOCATE = 1'b1
    } state_t;

    state_t             state_q;
    logic               mem_read_q;
    logic [AW-3:0]      miss_addr_q;

    logic               valid_q [BLOCKS];
    logic [TW-1:0]      tag_q   [BLOCKS];
    logic [127:0]       data_q  [BLOCKS];

    logic [1:0]         w_offset;
    logic [IW-1:0]      w_index;
    logic [TW-1:0]      w_tag;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill;
    logic [IW-1:0]      w_fill_index;
    logic [TW-1:0]      w_fill_tag;
    logic [127:0]       w_line;

    assign w_offset = proc_addr_i[1:0];
    assign w_index  = proc_addr_i[IW+1:2];
    assign w_tag    = proc_addr_i[AW-1:IW+2];

    assign w_hit  = proc_read_i && valid_q[w_index] && (tag_q[w_index] == w_tag);
    assign w_miss = (state_q == S_COMPARE) && proc_read_i && !w_hit;

    // The refilled line is always addressed from the latched miss address,
    // never from the live fetch address, which may have moved on.
    assign w_fill       = (state_q == S_ALLOCATE) && mem_ready_i;
    assign w_fill_index = miss_addr_q[IW-1:0];
    assign w_fill_tag   = miss_addr_q[AW-3:IW];

    assign w_line = data_q[w_index];

    always_comb begin
        proc_rdata_o = w_line[31:0];
        case (w_offset)
            2'd0:    proc_rdata_o = w_line[31:0];
            2'd1:    proc_rdata_o = w_line[63:32];
            2'd2:    proc_rdata_o = w_line[95:64];
            default: proc_rdata_o = w_line[127:96];
        endcase
    end

    assign proc_stall_o = (state_q == S_ALLOCATE) || w_miss;
    assign mem_read_o   = mem_read_q;
    assign mem_addr_o   = miss_addr_q;

    // Control FSM; mem_read is a registered copy of "next state is ALLOCATE".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_COMPARE;
            mem_read_q  <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            case (state_q)
                S_COMPARE: begin
                    if (w_miss) begin
                        miss_addr_q <= proc_addr_i[AW-1:2];
                        state_q     <= S_ALLOCATE;
                        mem_read_q  <= 1'b1;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ready_i) begin
                        state_q    <= S_COMPARE;
                        mem_read_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_COMPARE;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLOCKS; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (w_fill) begin
            valid_q[w_fill_index] <= 1'b1;
            tag_q[w_fill_index]   <= w_fill_tag;
            data_q[w_fill_index]  <= mem_rdata_i;
        end
    end

endmodule

`default_nettype wire
